// File: rtl/pkt_field_extractor_pkg.sv
// Shared packet-format constants for the RX parser, the node-info block and the TX builder.
// The parser FSM state type is included; S_CSUM is only reachable when PKT_CHECKSUM_EN is defined.
package pkt_field_extractor_pkg;

    localparam logic [2:0] PKT_HB   = 3'b000;
    localparam logic [2:0] PKT_CHA  = 3'b001;
    localparam logic [2:0] PKT_TS   = 3'b100;
    localparam logic [2:0] PKT_DATA = 3'b101;

    localparam logic [4:0] LEN_HB  = 5'd4;
    localparam logic [4:0] LEN_CHA = 5'd1;
    localparam logic [4:0] LEN_TS  = 5'd1;

    localparam logic [15:0] BCAST_ID = 16'hFFFF;

    localparam int HDR_TYPE_MSB = 15;
    localparam int HDR_TYPE_LSB = 13;
    localparam int HDR_LEN_MSB  = 4;
    localparam int HDR_LEN_LSB  = 0;

    // Heartbeat is the widest fixed-format payload.
    localparam int SHADOW_WORDS = 4;

    typedef enum logic [2:0] {
        S_HDR,
        S_SRC,
        S_DST,
        S_PAY,
        S_DROP,
        S_CSUM,
        S_COMMIT
    } state_t;

    function automatic logic len_ok(input logic [2:0] pkt_type,
                                    input logic [4:0] len,
                                    input logic [4:0] max_len);
        case (pkt_type)
            PKT_HB:   return len == LEN_HB;
            PKT_CHA:  return len == LEN_CHA;
            PKT_TS:   return len == LEN_TS;
            PKT_DATA: return len <= max_len;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pkt_field_extractor_if.sv
// RX word stream from the RX FIFO: 16-bit words over a valid/ready handshake.
interface pkt_field_extractor_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pkt_field_extractor_xor_checksum.sv
// pkt_xor_checksum: running XOR over packet words; match compares the sum so far
// with the word currently presented (the trailing checksum word).
module pkt_xor_checksum (
    input  logic        clk,
    input  logic        nrst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] din,
    output logic        match
);
    logic [15:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = en ? din : 16'h0000;
        end else if (en) begin
            acc_d = acc_q ^ din;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign match = (acc_q == din);
endmodule

// File: rtl/pkt_field_extractor.sv
// RX packet parser: filters on destination/type/length and publishes type-specific fields
// with a one-cycle en_mni strobe. Optional trailing XOR word when PKT_CHECKSUM_EN is defined.
module pkt_field_extractor #(
    parameter int          MAX_LEN  = 16,
    parameter logic [15:0] BCAST_ID = pkt_field_extractor_pkg::BCAST_ID
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [15:0]          my_node_id,
    pkt_field_extractor_if.slave rx,
    output logic [2:0]           f_pkt_type,
    output logic [15:0]          hops,
    output logic [15:0]          e_max,
    output logic [15:0]          e_min,
    output logic [15:0]          e_threshold,
    output logic [15:0]          ch_id,
    output logic [15:0]          timeslot,
    output logic                 en_mni,
    output logic                 pkt_drop,
    output logic                 busy
);
    import pkt_field_extractor_pkg::*;

    localparam logic [4:0] MAX_LEN_W = (MAX_LEN > 31) ? 5'd31 : 5'(MAX_LEN);

    state_t      state_q, state_d, after_pay;
    logic [2:0]  type_q, type_d;
    logic [4:0]  len_q, len_d, cnt_q, cnt_d, drop_last;
    logic [15:0] shadow_q [SHADOW_WORDS];
    logic [15:0] shadow_d [SHADOW_WORDS];
    logic        drop_q, drop_d;
    logic        accept, dest_ok, pkt_good, commit;

    logic [2:0]  f_pkt_type_q, f_pkt_type_d;
    logic [15:0] hops_q, hops_d, e_max_q, e_max_d, e_min_q, e_min_d;
    logic [15:0] e_thr_q, e_thr_d, ch_id_q, ch_id_d, timeslot_q, timeslot_d;

    assign accept   = rx.in_valid && rx.in_ready;
    assign dest_ok  = (rx.in_data == my_node_id) || (rx.in_data == BCAST_ID);
    assign pkt_good = dest_ok && len_ok(type_q, len_q, MAX_LEN_W);

`ifdef PKT_CHECKSUM_EN
    logic csum_clr, csum_en, csum_match;

    assign csum_clr = (state_q == S_HDR) && accept;
    assign csum_en  = accept && ((state_q == S_HDR) || (state_q == S_SRC) ||
                                 (state_q == S_DST) || (state_q == S_PAY));

    pkt_xor_checksum u_csum (
        .clk   (clk),
        .nrst  (nrst),
        .clr   (csum_clr),
        .en    (csum_en),
        .din   (rx.in_data),
        .match (csum_match)
    );

    // A dropped packet still carries its checksum word, so S_DROP runs one word longer.
    assign after_pay = S_CSUM;
    assign drop_last = len_q;
`else
    assign after_pay = S_COMMIT;
    assign drop_last = len_q - 5'd1;
`endif

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        drop_d   = 1'b0;

        case (state_q)
            S_HDR: if (accept) begin
                type_d  = rx.in_data[HDR_TYPE_MSB:HDR_TYPE_LSB];
                len_d   = rx.in_data[HDR_LEN_MSB:HDR_LEN_LSB];
                cnt_d   = '0;
                state_d = S_SRC;
            end
            S_SRC: if (accept) state_d = S_DST;
            S_DST: if (accept) begin
                if (pkt_good) begin
                    state_d = (len_q == 5'd0) ? after_pay : S_PAY;
                end else if ((len_q == 5'd0) && (after_pay == S_COMMIT)) begin
                    drop_d  = 1'b1;
                    state_d = S_HDR;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_PAY: if (accept) begin
                if (cnt_q < 5'(SHADOW_WORDS)) shadow_d[cnt_q[1:0]] = rx.in_data;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == len_q - 5'd1) state_d = after_pay;
            end
            S_DROP: if (accept) begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == drop_last) begin
                    drop_d  = 1'b1;
                    state_d = S_HDR;
                end
            end
`ifdef PKT_CHECKSUM_EN
            S_CSUM: if (accept) begin
                if (csum_match) begin
                    state_d = S_COMMIT;
                end else begin
                    drop_d  = 1'b1;
                    state_d = S_HDR;
                end
            end
`endif
            S_COMMIT: state_d = S_HDR;
            default:  state_d = S_HDR;
        endcase
    end

    // Published fields are visible during the commit cycle itself so the node-info block
    // can capture them on the same edge that ends en_mni.
    assign commit = nrst && (state_q == S_COMMIT);

    always_comb begin
        f_pkt_type_d = commit ? type_q : f_pkt_type_q;
        hops_d       = hops_q;
        e_max_d      = e_max_q;
        e_min_d      = e_min_q;
        e_thr_d      = e_thr_q;
        ch_id_d      = ch_id_q;
        timeslot_d   = timeslot_q;
        if (commit && (type_q == PKT_HB)) begin
            hops_d  = shadow_q[0];
            e_max_d = shadow_q[1];
            e_min_d = shadow_q[2];
            e_thr_d = shadow_q[3];
        end
        if (commit && (type_q == PKT_CHA)) ch_id_d    = shadow_q[0];
        if (commit && (type_q == PKT_TS))  timeslot_d = shadow_q[0];
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= S_HDR;
            type_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            shadow_q     <= '{default: '0};
            drop_q       <= 1'b0;
            f_pkt_type_q <= 3'b111;
            hops_q       <= '0;
            e_max_q      <= '0;
            e_min_q      <= '0;
            e_thr_q      <= '0;
            ch_id_q      <= '0;
            timeslot_q   <= '0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            drop_q       <= drop_d;
            f_pkt_type_q <= f_pkt_type_d;
            hops_q       <= hops_d;
            e_max_q      <= e_max_d;
            e_min_q      <= e_min_d;
            e_thr_q      <= e_thr_d;
            ch_id_q      <= ch_id_d;
            timeslot_q   <= timeslot_d;
        end
    end

    assign rx.in_ready = nrst && (state_q != S_COMMIT);
    assign en_mni      = commit;
    assign pkt_drop    = nrst && drop_q;
    assign busy        = nrst && (state_q != S_HDR);

    assign f_pkt_type  = f_pkt_type_d;
    assign hops        = hops_d;
    assign e_max       = e_max_d;
    assign e_min       = e_min_d;
    assign e_threshold = e_thr_d;
    assign ch_id       = ch_id_d;
    assign timeslot    = timeslot_d;
endmodule

// File: tb/tb_pkt_field_extractor.sv
// Bench for pkt_field_extractor: packet-level reference model checked every cycle,
// directed cases from the test plan, then randomized packets. Honors PKT_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_pkt_field_extractor;

`ifdef PKT_CHECKSUM_EN
    localparam int CSUM_WORDS = 1;
`else
    localparam int CSUM_WORDS = 0;
`endif

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [15:0] my_node_id = 16'h000C;
    logic [2:0]  f_pkt_type;
    logic [15:0] hops, e_max, e_min, e_threshold, ch_id, timeslot;
    logic        en_mni, pkt_drop, busy;

    pkt_field_extractor_if rx ();

    pkt_field_extractor #(.MAX_LEN(16)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .my_node_id  (my_node_id),
        .rx          (rx),
        .f_pkt_type  (f_pkt_type),
        .hops        (hops),
        .e_max       (e_max),
        .e_min       (e_min),
        .e_threshold (e_threshold),
        .ch_id       (ch_id),
        .timeslot    (timeslot),
        .en_mni      (en_mni),
        .pkt_drop    (pkt_drop),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int en_seen = 0;
    int drop_seen = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level reference model ----------------
    logic [15:0] pw[$];
    logic [2:0]  m_type = 3'b111;
    logic [15:0] m_hops = 0, m_emax = 0, m_emin = 0, m_ethr = 0, m_ch = 0, m_ts = 0;
    bit          m_en = 0, m_drop = 0;

    function automatic int pkt_total(input logic [15:0] hdr);
        return 3 + int'(hdr[4:0]) + CSUM_WORDS;
    endfunction

    task automatic judge();
        logic [2:0]  t;
        int          len;
        bit          ok;
        logic [15:0] x;
        t   = pw[0][15:13];
        len = int'(pw[0][4:0]);
        ok  = (pw[2] == my_node_id) || (pw[2] == 16'hFFFF);
        case (t)
            3'b000:         ok = ok && (len == 4);
            3'b001, 3'b100: ok = ok && (len == 1);
            3'b101:         ok = ok && (len <= 16);
            default:        ok = 0;
        endcase
        if (CSUM_WORDS == 1) begin
            x = 16'h0000;
            for (int i = 0; i < pw.size() - 1; i++) x = x ^ pw[i];
            ok = ok && (x == pw[pw.size() - 1]);
        end
        if (ok) begin
            m_en   = 1;
            m_type = t;
            if (t == 3'b000) begin
                m_hops = pw[3]; m_emax = pw[4]; m_emin = pw[5]; m_ethr = pw[6];
            end
            if (t == 3'b001) m_ch = pw[3];
            if (t == 3'b100) m_ts = pw[3];
        end else begin
            m_drop = 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        m_en = 0;
        m_drop = 0;
        if (!nrst) begin
            pw.delete();
            m_type = 3'b111;
            m_hops = 0; m_emax = 0; m_emin = 0; m_ethr = 0; m_ch = 0; m_ts = 0;
        end else if (rx.in_valid && rx.in_ready) begin
            pw.push_back(rx.in_data);
            if (pw.size() == pkt_total(pw[0])) begin
                judge();
                pw.delete();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        #2;
        if (!nrst) begin
            chk("rst_en_mni", en_mni, 0);
            chk("rst_pkt_drop", pkt_drop, 0);
            chk("rst_busy", busy, 0);
        end else begin
            chk("en_mni", en_mni, m_en);
            chk("pkt_drop", pkt_drop, m_drop);
            chk("busy", busy, (pw.size() > 0) || m_en);
            chk("in_ready", rx.in_ready, !m_en);
            chk("f_pkt_type", f_pkt_type, m_type);
            chk("hops", hops, m_hops);
            chk("e_max", e_max, m_emax);
            chk("e_min", e_min, m_emin);
            chk("e_threshold", e_threshold, m_ethr);
            chk("ch_id", ch_id, m_ch);
            chk("timeslot", timeslot, m_ts);
        end
        if (en_mni) en_seen++;
        if (pkt_drop) drop_seen++;
    end

    // ---------------- stimulus ----------------
    logic [15:0] txq[$];

    task automatic send_word(input logic [15:0] w, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx.in_data  = w;
        rx.in_valid = 1'b1;
        n = 0;
        while (!rx.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx.in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready=0 for %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1 rx.in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rx.in_valid = 1'b0;
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic finish_pkt(input bit bad);
        logic [15:0] x;
        if (CSUM_WORDS == 1) begin
            x = 16'h0000;
            foreach (txq[i]) x = x ^ txq[i];
            txq.push_back(bad ? (x ^ 16'h0001) : x);
        end
    endtask

    // gap_mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
    task automatic send_q(input int gap_mode, input int rst_after);
        int g;
        for (int i = 0; i < txq.size(); i++) begin
            if (rst_after > 0 && i == rst_after) begin
                pulse_reset();
                return;
            end
            g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
            send_word(txq[i], g);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_hb(input logic [15:0] hdr, input logic [15:0] dst,
                           input logic [15:0] p0, p1, p2, p3, input int n);
        txq.delete();
        txq.push_back(hdr);
        txq.push_back(16'h0003);
        txq.push_back(dst);
        if (n > 0) txq.push_back(p0);
        if (n > 1) txq.push_back(p1);
        if (n > 2) txq.push_back(p2);
        if (n > 3) txq.push_back(p3);
    endtask

    task automatic load_one(input logic [15:0] hdr, input logic [15:0] dst, input logic [15:0] p0);
        txq.delete();
        txq.push_back(hdr);
        txq.push_back(16'h0003);
        txq.push_back(dst);
        txq.push_back(p0);
    endtask

    int e0, d0, rst_after, r, len;
    logic [2:0]  t;
    logic [15:0] dst;

    initial begin
        rx.in_data  = 16'h0000;
        rx.in_valid = 1'b0;
        idle(3);
        nrst = 1'b1;
        #2;
        chk("reset_f_pkt_type", f_pkt_type, 16'h0007);
        chk("reset_hops", hops, 16'h0000);

        // Heartbeat to broadcast, no gaps
        load_hb(16'h0004, 16'hFFFF, 16'h0005, 16'h0900, 16'h0100, 16'h0200, 4);
        finish_pkt(0);
`ifdef PKT_CHECKSUM_EN
        chk("t1_csum_word", txq[7], 16'hF5FD);
`endif
        e0 = en_seen;
        send_q(0, 0);
        @(negedge clk);
        #2;
        chk("t1_en_latency", en_mni, 1);
        chk("t1_type", f_pkt_type, 16'h0000);
        chk("t1_hops", hops, 16'h0005);
        chk("t1_e_max", e_max, 16'h0900);
        chk("t1_e_min", e_min, 16'h0100);
        chk("t1_e_thr", e_threshold, 16'h0200);
        idle(3);
        chk("t1_en_count", 16'(en_seen - e0), 1);

        // CH announce, valid toggled every other cycle
        load_one(16'h2001, 16'h000C, 16'h000C);
        finish_pkt(0);
        e0 = en_seen;
        send_q(1, 0);
        idle(3);
        chk("t2_ch_id", ch_id, 16'h000C);
        chk("t2_en_count", 16'(en_seen - e0), 1);
        chk("t2_hops_held", hops, 16'h0005);
        chk("t2_e_thr_held", e_threshold, 16'h0200);

        // Timeslot addressed elsewhere
        load_one(16'h8001, 16'h0007, 16'h0042);
        finish_pkt(0);
        e0 = en_seen; d0 = drop_seen;
        send_q(0, 0);
        idle(3);
        chk("t3_drop_count", 16'(drop_seen - d0), 1);
        chk("t3_en_count", 16'(en_seen - e0), 0);
        chk("t3_timeslot_held", timeslot, 16'h0000);

        // Heartbeat with wrong length, then a good CH packet
        load_hb(16'h0003, 16'hFFFF, 16'h1111, 16'h2222, 16'h3333, 16'h0000, 3);
        finish_pkt(0);
        d0 = drop_seen;
        send_q(0, 0);
        idle(2);
        chk("t4_drop_count", 16'(drop_seen - d0), 1);
        load_one(16'h2001, 16'hFFFF, 16'h0ABC);
        finish_pkt(0);
        send_q(0, 0);
        idle(2);
        chk("t4_ch_id", ch_id, 16'h0ABC);

        // Reset after the second heartbeat payload word, then a fresh heartbeat
        load_hb(16'h0004, 16'h000C, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 4);
        finish_pkt(0);
        send_q(0, 5);
        #2;
        chk("t5_rst_type", f_pkt_type, 16'h0007);
        chk("t5_rst_hops", hops, 16'h0000);
        chk("t5_rst_ch_id", ch_id, 16'h0000);
        chk("t5_rst_busy", busy, 0);
        load_hb(16'h0004, 16'h000C, 16'h0007, 16'h0A00, 16'h0050, 16'h0300, 4);
        finish_pkt(0);
        send_q(2, 0);
        @(negedge clk);
        #2;
        chk("t5_en", en_mni, 1);
        chk("t5_hops", hops, 16'h0007);
        chk("t5_e_max", e_max, 16'h0A00);

        // Data length boundaries: 16 commits, 17 drops
        txq.delete();
        txq.push_back(16'hA010); txq.push_back(16'h0001); txq.push_back(16'h000C);
        for (int i = 0; i < 16; i++) txq.push_back(16'(i * 3));
        finish_pkt(0);
        send_q(0, 0);
        @(negedge clk);
        #2;
        chk("t6_data16_en", en_mni, 1);
        chk("t6_data16_type", f_pkt_type, 16'h0005);
        txq.delete();
        txq.push_back(16'hA011); txq.push_back(16'h0001); txq.push_back(16'h000C);
        for (int i = 0; i < 17; i++) txq.push_back(16'(i));
        finish_pkt(0);
        d0 = drop_seen;
        send_q(0, 0);
        idle(2);
        chk("t7_data17_drop", 16'(drop_seen - d0), 1);

`ifdef PKT_CHECKSUM_EN
        // Heartbeat with a corrupted checksum word
        load_hb(16'h0004, 16'hFFFF, 16'h0005, 16'h0900, 16'h0100, 16'h0200, 4);
        finish_pkt(1);
        e0 = en_seen; d0 = drop_seen;
        send_q(0, 0);
        idle(3);
        chk("t8_bad_csum_drop", 16'(drop_seen - d0), 1);
        chk("t8_bad_csum_en", 16'(en_seen - e0), 0);
`endif

        // Randomized packets
        for (int p = 0; p < 80; p++) begin
            r = int'($urandom_range(0, 9));
            t = (r < 3) ? 3'b000 : (r < 5) ? 3'b001 : (r < 7) ? 3'b100 :
                (r < 9) ? 3'b101 : 3'($urandom_range(0, 7));
            case (t)
                3'b000:         len = 4;
                3'b001, 3'b100: len = 1;
                3'b101:         len = int'($urandom_range(0, 20));
                default:        len = int'($urandom_range(0, 5));
            endcase
            if ($urandom_range(0, 3) == 0) len = int'($urandom_range(0, 31));
            r = int'($urandom_range(0, 5));
            dst = (r < 2) ? my_node_id : (r < 4) ? 16'hFFFF : 16'($urandom());
            txq.delete();
            txq.push_back({t, 8'($urandom()), 5'(len)});
            txq.push_back(16'($urandom()));
            txq.push_back(dst);
            for (int i = 0; i < len; i++) txq.push_back(16'($urandom()));
            finish_pkt($urandom_range(0, 5) == 0);
            rst_after = ($urandom_range(0, 14) == 0) ?
                        int'($urandom_range(1, txq.size() - 1)) : 0;
            send_q(int'($urandom_range(0, 2)), rst_after);
            if ($urandom_range(0, 9) == 0) my_node_id = 16'($urandom_range(0, 15));
        end

        idle(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pkt_field_extractor.md
Name: pkt_field_extractor

Overview:
- Receive-side parser that sits directly upstream of the node-info register block.
- Consumes 16-bit words of one received packet from the RX word FIFO over a valid/ready handshake, then filters the packet on destination ID and length.
- On a good packet it latches the type-specific fields and issues a one-cycle en_mni strobe with f_pkt_type, so the node-info block can capture them.
- Dropped packets are consumed completely and never disturb the published fields.

Parameters:
- MAX_LEN, 16, largest accepted payload length in words; longer packets are consumed and dropped.
- BCAST_ID, 16'hFFFF, destination ID accepted by every node.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- my_node_id  in  16  this node's ID, used for destination filtering
- in_data  in  16  RX word
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid && in_ready
- f_pkt_type  out  3  type of the last committed packet
- hops, e_max, e_min, e_threshold  out  16 each  heartbeat fields
- ch_id  out  16  cluster-head ID from a CH-announce packet
- timeslot  out  16  TDMA slot from a schedule packet
- en_mni  out  1  one-cycle commit strobe
- pkt_drop  out  1  one-cycle strobe when a packet is discarded
- busy  out  1  high from header accept until commit or drop completes

Behaviour:
- Packet format, in word order:
  - w0 header: [15:13] type, [4:0] len = number of payload words; other bits ignored.
  - w1: source ID.
  - w2: destination ID.
  - Then len payload words.
- Expected payload length and word order per type:
  - 000 heartbeat, len 4: hops, e_max, e_min, e_threshold.
  - 001 CH announce, len 1: ch_id.
  - 100 timeslot, len 1: timeslot.
  - 101 data, any len from 0 to MAX_LEN: payload words discarded, commit only.
  - Any other type is dropped.
- FSM states: S_HDR, S_SRC, S_DST, S_PAY, S_DROP, S_COMMIT.
  - S_HDR: on accept, latch type and len, go to S_SRC.
  - S_SRC: accept and ignore the word, go to S_DST.
  - S_DST: accept the word. A packet is good if dest == my_node_id or dest == BCAST_ID, type is known, and len matches the expected value (or len <= MAX_LEN for data).
    - Good and len == 0: go to S_COMMIT.
    - Good and len > 0: go to S_PAY.
    - Bad and len == 0: pulse pkt_drop on the next cycle, go to S_HDR.
    - Bad and len > 0: go to S_DROP.
  - S_PAY: payload words go into shadow registers indexed by a 5-bit word counter. After the last word, go to S_COMMIT.
  - S_DROP: consume the remaining len words. After the last word, pulse pkt_drop and go to S_HDR.
  - S_COMMIT: lasts one cycle, in_ready = 0.
    - Copy the shadow registers for this packet type to the outputs.
    - Set f_pkt_type and assert en_mni.
    - Go to S_HDR.
- Only the fields belonging to the committed type update; all others hold their values.
- in_ready = 1 in every state except S_COMMIT. in_valid low simply stalls the current state with no timeout.
- Latency: en_mni is asserted exactly one cycle after the last payload word is accepted (after the dest word when len == 0).
- Reset:
  - Any cycle with nrst low, including mid-packet, returns the FSM to S_HDR and clears the counter and shadow registers.
  - All outputs reset to 0, except f_pkt_type resets to 3'b111.
  - en_mni, pkt_drop and busy are 0 during reset.
- The counter compares against the latched len only, so there is no wrap-around. A len up to 31 is legal on the wire and is always consumed fully.
- my_node_id is sampled in S_DST only.

Optional Feature:
- PKT_CHECKSUM_EN defined:
  - Each packet carries one extra trailing word equal to the XOR of all preceding words (header through last payload).
  - This word is accepted in a checksum state after S_PAY, or directly after S_DST when len == 0.
  - On mismatch: pkt_drop pulses and there is no commit. Commit latency is measured from the checksum word.
  - In S_DROP, the trailing word is also consumed.
- PKT_CHECKSUM_EN undefined: no trailing word; behaviour as above.

Decomposition:
- Shared package holds:
  - pkt type localparams: PKT_HB=3'b000, PKT_CHA=3'b001, PKT_TS=3'b100, PKT_DATA=3'b101.
  - Expected lengths: LEN_HB=4, LEN_CHA=1, LEN_TS=1.
  - BCAST_ID.
  - Header bit positions.
- These constants are shared with the node-info block and the TX packet builder.
- One sub-module: pkt_xor_checksum, a running XOR accumulator with clear, enable and match output. It is instantiated only under PKT_CHECKSUM_EN.

Test Plan:
- Heartbeat to BCAST_ID, words 16'h0004, 16'h0003, 16'hFFFF, 5, 16'h0900, 16'h0100, 16'h0200, with no valid gaps:
  - en_mni is high one cycle after the last word.
  - f_pkt_type=000, hops=5, e_max=16'h0900, e_min=16'h0100, e_threshold=16'h0200.
- CH announce to my_node_id=16'h000C carrying ch_id=16'h000C, with in_valid toggled every other cycle:
  - ch_id=16'h000C and en_mni pulses once.
  - Heartbeat fields are unchanged.
- Timeslot packet with dest=16'h0007 while my_node_id=16'h000C:
  - Payload is consumed, pkt_drop pulses once, en_mni stays 0, timeslot is unchanged.
- Heartbeat header with len=3:
  - All 3 payload words are consumed, then pkt_drop pulses.
  - A following valid CH packet is parsed correctly.
- nrst pulsed low after the second payload word of a heartbeat, followed by a fresh valid heartbeat:
  - Outputs are zero with f_pkt_type=111 after reset.
  - The fresh packet commits normally.
- With PKT_CHECKSUM_EN: the heartbeat above with a correct XOR word commits; the same packet with the XOR word bit-flipped produces pkt_drop and no en_mni.
